// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: two-stage valid/ready bitwise gate unit with wrapping result counter.
// Define LOGIC_GATE_PIPE_PARITY_EN to add the registered even-parity output y_par.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] done_cnt
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    ,
    output logic             y_par
`endif
);
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] result;
    logic             in_hs, out_hs, s2_load;

    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    // S1 can refill in the same cycle it drains into S2, keeping full throughput
    assign in_ready = !s1_valid || !out_valid || out_ready;

    always_comb begin
        result = '0;
        case (s1_op)
            3'b000:  result = s1_a & s1_b;
            3'b001:  result = s1_a | s1_b;
            3'b010:  result = s1_a ^ s1_b;
            3'b011:  result = ~(s1_a & s1_b);
            3'b100:  result = ~(s1_a | s1_b);
            3'b101:  result = ~(s1_a ^ s1_b);
            3'b110:  result = ~s1_a;
            default: result = s1_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else begin
            s1_valid <= in_hs ? 1'b1 : (s2_load ? 1'b0 : s1_valid);
            if (in_hs) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_op <= op;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            done_cnt  <= '0;
        end else begin
            out_valid <= s2_load ? 1'b1 : (out_hs ? 1'b0 : out_valid);
            if (s2_load)
                y <= result;
            if (out_hs)
                done_cnt <= done_cnt + 1'b1;
        end
    end

`ifdef LOGIC_GATE_PIPE_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            y_par <= 1'b0;
        else if (s2_load)
            y_par <= ^result;
    end
`endif
endmodule
